// File: rtl/keypad_lock_ctrl_if.sv
// Keypad lock bus: one-hot key code in, display/status/buzzer out.
// Master drives the keypad code, slave is the lock controller.
interface keypad_lock_ctrl_if #(
  parameter int N_DIGITS = 3
);
  logic [15:0]           onehot;
  logic [4*N_DIGITS-1:0] digits;
  logic [3:0]            entry_cnt;
  logic [3:0]            tries;
  logic [1:0]            state;
  logic [7:0]            lock_remaining;
  logic                  unlocked;
  logic                  buzzer;

  modport master (
    output onehot,
    input  digits, entry_cnt, tries, state, lock_remaining, unlocked, buzzer
  );

  modport slave (
    input  onehot,
    output digits, entry_cnt, tries, state, lock_remaining, unlocked, buzzer
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Keypad password lock: N-digit BCD entry, password check, try limit, lockout countdown, buzzer tones.
// Outputs update one cycle after a key edge; no backpressure, keys in ignoring states are dropped.
module keypad_lock_ctrl #(
  parameter int                    N_DIGITS   = 3,
  parameter logic [4*N_DIGITS-1:0] PASSWORD   = 12'h246,
  parameter int                    MAX_TRIES  = 3,
  parameter int                    LOCK_SEC   = 20,
  parameter int                    CLK_HZ     = 50_000_000,
  parameter int                    CLICK_HALF = 50000,
  parameter int                    CLICK_LEN  = 10_000_000,
  parameter int                    OK_HALF    = 25000,
  parameter int                    OK_LEN     = 30_000_000,
  parameter int                    FAIL_HALF  = 100000,
  parameter int                    FAIL_LEN   = 15_000_000
) (
  input  logic              clk,
  input  logic              RSTn,
  keypad_lock_ctrl_if.slave kp
);
  localparam int            DW    = 4 * N_DIGITS;
  localparam logic [DW-1:0] BLANK = {N_DIGITS{4'hF}};
  localparam logic [DW-1:0] GLYPH = {N_DIGITS{4'hA}};
  localparam logic [3:0]    FULL  = 4'(N_DIGITS);

  typedef enum logic [1:0] {ST_ENTRY = 2'd0, ST_PASS = 2'd1, ST_LOCK = 2'd2} state_t;
  typedef enum logic [1:0] {T_IDLE, T_CLICK, T_OK, T_FAIL} tone_t;
  typedef enum logic [2:0] {K_NONE, K_DIG, K_ENTER, K_BS, K_CLR, K_CLRALL} key_t;

  logic [15:0]   r_onehot_prev;
  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_digits, w_digits_nx;
  logic [3:0]    r_cnt, w_cnt_nx;
  logic [3:0]    r_tries, w_tries_nx;
  logic [7:0]    r_lrem, w_lrem_nx;
  logic [31:0]   r_presc, w_presc_nx;
  tone_t         r_tone, w_tone_req;
  logic [31:0]   r_dur, r_half, w_half, w_len;
  logic          r_buzz, w_gap;
  key_t          w_key;
  logic [3:0]    w_dig;
  logic          w_evt;

  always_comb begin
    w_key = K_DIG;
    w_dig = 4'd0;
    case (kp.onehot)
      16'h0008: w_dig = 4'd0;
      16'h0080: w_dig = 4'd1;
      16'h0040: w_dig = 4'd2;
      16'h0020: w_dig = 4'd3;
      16'h0800: w_dig = 4'd4;
      16'h0400: w_dig = 4'd5;
      16'h0200: w_dig = 4'd6;
      16'h8000: w_dig = 4'd7;
      16'h4000: w_dig = 4'd8;
      16'h2000: w_dig = 4'd9;
      16'h0001: w_key = K_ENTER;
      16'h0010: w_key = K_BS;
      16'h1000: w_key = K_CLR;
      16'h0100: w_key = K_CLRALL;
      default:  w_key = K_NONE;
    endcase
  end

  // Only a press from an all-released keypad counts, so a held key fires once.
  assign w_evt = (r_onehot_prev == 16'h0) && (w_key != K_NONE);

  always_comb begin
    w_state_nx  = r_state;
    w_digits_nx = r_digits;
    w_cnt_nx    = r_cnt;
    w_tries_nx  = r_tries;
    w_lrem_nx   = r_lrem;
    w_presc_nx  = r_presc;
    w_tone_req  = T_IDLE;
    case (r_state)
      ST_ENTRY: begin
        if (w_evt) begin
          case (w_key)
            K_DIG: if (r_cnt < FULL) begin
              w_digits_nx = (r_digits << 4) | DW'(w_dig);
              w_cnt_nx    = r_cnt + 4'd1;
              w_tone_req  = T_CLICK;
            end
            K_BS: if (r_cnt != 4'd0) begin
              w_digits_nx = (r_digits >> 4) | (DW'(4'hF) << (DW - 4));
              w_cnt_nx    = r_cnt - 4'd1;
              w_tone_req  = T_CLICK;
            end
            K_CLR, K_CLRALL: begin
              w_digits_nx = BLANK;
              w_cnt_nx    = 4'd0;
              w_tone_req  = T_CLICK;
              if (w_key == K_CLRALL) w_tries_nx = 4'd0;
            end
            K_ENTER: if (r_cnt == FULL) begin
              if (r_digits == PASSWORD) begin
                w_state_nx  = ST_PASS;
                w_digits_nx = GLYPH;
                w_tries_nx  = 4'd0;
                w_tone_req  = T_OK;
              end else begin
                w_digits_nx = BLANK;
                w_cnt_nx    = 4'd0;
                w_tone_req  = T_FAIL;
                if (r_tries + 4'd1 == 4'(MAX_TRIES)) begin
                  w_state_nx  = ST_LOCK;
                  w_tries_nx  = 4'd0;
                  w_digits_nx = '0;
                  w_lrem_nx   = 8'(LOCK_SEC);
                  w_presc_nx  = '0;
                end else begin
                  w_tries_nx = r_tries + 4'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_PASS: begin
        if (w_evt && (w_key == K_CLR || w_key == K_CLRALL)) begin
          w_state_nx  = ST_ENTRY;
          w_digits_nx = BLANK;
          w_cnt_nx    = 4'd0;
          w_tone_req  = T_CLICK;
        end
      end
      ST_LOCK: begin
        if (r_presc == 32'(CLK_HZ - 1)) begin
          w_presc_nx = '0;
          w_lrem_nx  = r_lrem - 8'd1;
          if (r_lrem == 8'd1) begin
            w_state_nx  = ST_ENTRY;
            w_digits_nx = BLANK;
            w_cnt_nx    = 4'd0;
          end
        end else begin
          w_presc_nx = r_presc + 32'd1;
        end
      end
      default: w_state_nx = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge RSTn) begin
    if (RSTn) begin
      r_onehot_prev <= '0;
      r_state       <= ST_ENTRY;
      r_digits      <= BLANK;
      r_cnt         <= '0;
      r_tries       <= '0;
      r_lrem        <= '0;
      r_presc       <= '0;
    end else begin
      r_onehot_prev <= kp.onehot;
      r_state       <= w_state_nx;
      r_digits      <= w_digits_nx;
      r_cnt         <= w_cnt_nx;
      r_tries       <= w_tries_nx;
      r_lrem        <= w_lrem_nx;
      r_presc       <= w_presc_nx;
    end
  end

  always_comb begin
    case (r_tone)
      T_OK:    begin w_half = 32'(OK_HALF);    w_len = 32'(OK_LEN);    end
      T_FAIL:  begin w_half = 32'(FAIL_HALF);  w_len = 32'(FAIL_LEN);  end
      default: begin w_half = 32'(CLICK_HALF); w_len = 32'(CLICK_LEN); end
    endcase
  end

  // A new request always wins, so any key restarts whatever tone is playing.
  always_ff @(posedge clk or posedge RSTn) begin
    if (RSTn) begin
      r_tone <= T_IDLE;
      r_dur  <= '0;
      r_half <= '0;
      r_buzz <= 1'b0;
    end else if (w_tone_req != T_IDLE) begin
      r_tone <= w_tone_req;
      r_dur  <= '0;
      r_half <= '0;
      r_buzz <= 1'b1;
    end else if (r_tone != T_IDLE) begin
      if (r_dur == w_len - 32'd1) begin
        r_tone <= T_IDLE;
        r_buzz <= 1'b0;
      end else begin
        r_dur <= r_dur + 32'd1;
        if (r_half == w_half - 32'd1) begin
          r_half <= '0;
          r_buzz <= ~r_buzz;
        end else begin
          r_half <= r_half + 32'd1;
        end
      end
    end
  end

  assign w_gap = (r_tone == T_FAIL) && (r_dur > 32'(FAIL_LEN / 3)) &&
                 (r_dur < 32'(2 * FAIL_LEN / 3));

  assign kp.digits         = r_digits;
  assign kp.entry_cnt      = r_cnt;
  assign kp.tries          = r_tries;
  assign kp.state          = r_state;
  assign kp.lock_remaining = r_lrem;
  assign kp.unlocked       = (r_state == ST_PASS);
  assign kp.buzzer         = r_buzz & ~w_gap;
endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Parametrised successor to the 3-digit keypad password lock. Takes the 16-bit one-hot keypad code from the keypad scanner and builds an N-digit BCD entry for the 7-segment display driver.
- Compares the entry against a parameter password and drives the buzzer with distinct click, success and fail patterns.
- Adds backspace, a configurable digit count and try limit, and a lockout countdown.

Parameters:
N_DIGITS, 3, number of password digits (1..8)
PASSWORD, 12'h246, BCD password, width 4*N_DIGITS, MS digit in top nibble
MAX_TRIES, 3, consecutive failures that trigger lockout (1..15)
LOCK_SEC, 20, lockout duration in seconds (1..255)
CLK_HZ, 50_000_000, clock cycles per second
CLICK_HALF / CLICK_LEN, 50000 / 10_000_000, key-click half-period / duration in cycles
OK_HALF / OK_LEN, 25000 / 30_000_000, success tone half-period / duration
FAIL_HALF / FAIL_LEN, 100000 / 15_000_000, fail tone half-period / duration

Ports:
clk  in  1  system clock
RSTn  in  1  reset, asynchronous, active-high (asserted = 1)
onehot  in  16  keypad one-hot code, 0 = no key
digits  out  4*N_DIGITS  display nibbles; 4'hF = blank, 4'hA = pass glyph
entry_cnt  out  4  digits currently entered
tries  out  4  consecutive failed attempts
state  out  2  0 ENTRY, 1 PASS, 2 LOCKOUT
lock_remaining  out  8  seconds left in lockout, 0 otherwise
unlocked  out  1  high in PASS
buzzer  out  1  buzzer drive

Behaviour:
- Reset values: digits all 4'hF, entry_cnt 0, tries 0, state ENTRY, lock_remaining 0, unlocked 0, buzzer 0. Internal onehot_prev, tone counters and second prescaler also clear to 0.
- Key event: registered onehot_prev; an event fires for one cycle when onehot_prev==0 and onehot is one of the mapped codes below. A held key gives exactly one event. Multi-hot and unmapped codes produce no event.
- Key map:
  - 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9
  - 0x0001=ENTER, 0x0010=BACKSPACE, 0x1000=CLEAR (entry), 0x0100=CLEAR_ALL (entry + tries)
- ENTRY state:
  - Digit with entry_cnt<N_DIGITS: digits <= {digits[4N-5:0], d}, entry_cnt+1, click tone.
  - Digit with entry full: ignored, no tone.
  - BACKSPACE with entry_cnt>0: digits <= {4'hF, digits[4N-1:4]}, entry_cnt-1, click tone. With entry_cnt 0: ignored.
  - CLEAR: digits blank, entry_cnt 0, click tone. CLEAR_ALL: same, plus tries 0.
  - ENTER with entry_cnt<N_DIGITS: ignored.
  - ENTER with entry full and digits==PASSWORD: go to PASS; digits all 4'hA; tries 0; OK tone.
  - ENTER with entry full and mismatch: blank entry, FAIL tone. If tries+1==MAX_TRIES: go to LOCKOUT, tries 0, digits all 4'h0, lock_remaining=LOCK_SEC, prescaler 0. Otherwise tries+1.
  - All register updates take effect on the cycle after the event cycle (1-cycle latency from the onehot rising edge to outputs).
- PASS state: unlocked=1. CLEAR or CLEAR_ALL returns to ENTRY with blank entry, unlocked 0, click tone. All other keys ignored.
- LOCKOUT state:
  - All keys ignored, including CLEAR_ALL.
  - Prescaler counts 0..CLK_HZ-1; at wrap, lock_remaining decrements.
  - The decrement to 0 returns to ENTRY with digits blank, entry_cnt 0, no tone.
  - A key event in the expiry cycle is ignored.
- Buzzer generator:
  - Single generator. Any new tone request restarts it: duration counter 0, half-period counter 0, buzzer 1.
  - buzzer toggles every HALF cycles until the duration counter reaches LEN, then forces buzzer 0 and goes idle.
  - FAIL pattern: buzzer forced 0 while the duration counter is in (FAIL_LEN/3, 2*FAIL_LEN/3).
  - When idle, buzzer 0.
- Reset asserted mid-operation (any state, any tone) returns immediately to reset values.

Test Plan:
- Correct code, defaults (N=3, PASSWORD 12'h246): keys 2,4,6 -> digits FF2, F24, 246, entry_cnt 3. ENTER -> state 1, unlocked 1, digits AAA, buzzer toggles every 25000 cycles for 30M cycles, then 0. CLEAR -> digits FFF, state 0.
- Backspace/overflow: keys 1,2,BS,4 -> FF1, F12, FF1, F14. Key 7 then 8 -> 147, 8 ignored (no tone). BS x4 -> FFF, entry_cnt 0, 4th BS silent.
- Lockout, with CLK_HZ=100, LOCK_SEC=3:
  - 3 wrong entries (111+ENTER) -> tries 1, then 2.
  - 3rd -> state 2, digits 000, lock_remaining 3.
  - Counts 2, 1 at 100-cycle intervals; reaches 0 -> state 0, digits FFF.
  - Keys pressed during lockout have no effect.
- Event filtering: hold key 0x0080 for 1000 cycles -> one digit. onehot 0x00C0 or 0x0002 -> no change. Release then 0x0080 -> second digit.
- Fail tone: wrong ENTER -> buzzer toggles at FAIL_HALF in the first third, 0 in the middle third, toggles in the last third, 0 after FAIL_LEN. A key mid-tone restarts it as a click.
- Reset/generalisation: N_DIGITS=4, PASSWORD 16'h1234 -> 1,2,3,4,ENTER unlocks (digits AAAA). Assert RSTn mid-lockout -> all outputs at reset values on the same edge.
